// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Sequential wrapper around the combinational 16-bit Q6.10 ALU. Commands
//   arrive on a valid/ready stream and queue in a DEPTH-entry FIFO. The FIFO
//   head is presented to the ALU operand/instruction inputs. The ALU result is
//   captured into a response register and returned on a valid/ready stream
//   that honours backpressure. No arithmetic is done here; all rounding and
//   saturation belong to the ALU.
//
// Parameters:
//   DEPTH  command FIFO entries (power of two, 2..16)
//   PTR_W  FIFO pointer width, derived from DEPTH (do not override)
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   cmd_valid_i  command present
//   cmd_ready_o  FIFO can accept a command (registered occupancy only)
//   cmd_inst_i   ALU opcode (0 add, 1 sub, 2 mul, 3 GeLU, 4 CLZ)
//   cmd_a_i      operand A, Q6.10
//   cmd_b_i      operand B, Q6.10
//   alu_a_o      ALU operand A (FIFO head, 0 when empty)
//   alu_b_o      ALU operand B (FIFO head, 0 when empty)
//   alu_inst_o   ALU instruction (FIFO head, 0 when empty)
//   alu_data_i   ALU result, combinational from alu_*_o
//   rsp_valid_o  response present
//   rsp_ready_i  consumer accepts the response
//   rsp_data_o   captured ALU result
//   rsp_inst_o   opcode that produced rsp_data_o
//   rsp_err_o    opcode was 5..7 (illegal)
//   count_o      FIFO occupancy
//   busy_o       FIFO non-empty or response pending
//
// Optional feature (macro ALU_PERF_CNT_EN):
//   perf_cmd_o   saturating count of completed response handshakes
//   perf_stall_o saturating count of cycles with cmd_valid_i && !cmd_ready_o
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_inst_i,
    input  logic [15:0]      cmd_a_i,
    input  logic [15:0]      cmd_b_i,
    output logic [15:0]      alu_a_o,
    output logic [15:0]      alu_b_o,
    output logic [2:0]       alu_inst_o,
    input  logic [15:0]      alu_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_data_o,
    output logic [2:0]       rsp_inst_o,
    output logic             rsp_err_o,
    output logic [PTR_W:0]   count_o,
    output logic             busy_o
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [15:0]      perf_cmd_o,
    output logic [15:0]      perf_stall_o
`endif
);

    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [2:0]        LAST_OP  = 3'd4;

    // EMPTY: nothing queued and no response pending.
    // RUN:   work present, response slot free or draining.
    // STALL: a pending response was refused at the last edge and is held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t state_q;

    // FIFO storage holds data only; reset discards entries via the pointers.
    logic signed [15:0] fifo_a [DEPTH];
    logic signed [15:0] fifo_b [DEPTH];
    logic        [2:0]  fifo_inst [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               vld_p0;
    logic               push;
    logic               cap;
    logic               rsp_take;
    logic [CNT_W-1:0]   count_nxt;
    logic               rsp_valid_nxt;

    // ---- stage p0: FIFO head drives the ALU ----
    assign vld_p0      = (count_o != '0);
    assign cmd_ready_o = (count_o != FULL_CNT);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign rsp_take    = rsp_valid_o && rsp_ready_i;
    // The head moves into the response slot whenever that slot is free or
    // being emptied at this same edge.
    assign cap         = vld_p0 && (!rsp_valid_o || rsp_ready_i);

    assign alu_a_o    = vld_p0 ? fifo_a[rd_ptr]    : '0;
    assign alu_b_o    = vld_p0 ? fifo_b[rd_ptr]    : '0;
    assign alu_inst_o = vld_p0 ? fifo_inst[rd_ptr] : '0;

    always_comb begin
        count_nxt = count_o;
        case ({push, cap})
            2'b10:   count_nxt = count_o + 1'b1;
            2'b01:   count_nxt = count_o - 1'b1;
            default: count_nxt = count_o;
        endcase
    end

    assign rsp_valid_nxt = cap || (rsp_valid_o && !rsp_take);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a[wr_ptr]    <= cmd_a_i;
            fifo_b[wr_ptr]    <= cmd_b_i;
            fifo_inst[wr_ptr] <= cmd_inst_i;
        end
    end

    // ---- stage p1: response register and sequencing state ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_o     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_inst_o  <= '0;
            rsp_err_o   <= 1'b0;
            state_q     <= ST_EMPTY;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (cap) begin
                rd_ptr     <= rd_ptr + 1'b1;
                rsp_data_o <= alu_data_i;
                rsp_inst_o <= fifo_inst[rd_ptr];
                rsp_err_o  <= (fifo_inst[rd_ptr] > LAST_OP);
            end
            count_o     <= count_nxt;
            rsp_valid_o <= rsp_valid_nxt;

            if ((count_nxt == '0) && !rsp_valid_nxt) begin
                state_q <= ST_EMPTY;
            end else if (rsp_valid_o && !rsp_ready_i) begin
                state_q <= ST_STALL;
            end else begin
                state_q <= ST_RUN;
            end
        end
    end

    // busy follows the registered state so it never sees input glitches.
    assign busy_o = (state_q != ST_EMPTY);

`ifdef ALU_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cmd_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (rsp_take && (perf_cmd_o != 16'hFFFF)) begin
                perf_cmd_o <= perf_cmd_o + 1'b1;
            end
            if (cmd_valid_i && !cmd_ready_o && (perf_stall_o != 16'hFFFF)) begin
                perf_stall_o <= perf_stall_o + 1'b1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
